e_mul_arbiter: RTL and testbench
================================

Name: e_mul_arbiter

Overview:
- Shares one multi-word (WORDS x 16-bit) multiplier between NREQ requesters, e.g. the squaring loop and the final multiply-by-n stage of the e calculation.
- Arbitrates round-robin, latches the winner's operands, and sequences the multiplier through a start/done pulse handshake.
- Captures the product and returns it to the winning requester with a one-cycle valid pulse.
- Sits between the requesting compute stages and a single multiplier instance.

Parameters:
- WORDS, 32, number of 16-bit limbs per operand and per product (word 0 = least significant).
- NREQ, 2, number of requesters (2..4).
- TIMEOUT_CYC, 65535, watchdog limit in cycles; used only with E_MUL_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester; held high until that requester's rsp_valid.
- req_a  in  [NREQ][WORDS]x16  operand A per requester; must be stable while its req is high.
- req_b  in  [NREQ][WORDS]x16  operand B per requester; same stability rule as req_a.
- gnt  out  NREQ  one-hot; high from the latch cycle through the RESP cycle for the owner.
- rsp_valid  out  NREQ  one-cycle pulse to the owner when the result is ready.
- rsp_data  out  [WORDS]x16  registered product; holds its value until the next capture.
- rsp_err  out  1  high alongside rsp_valid on a timeout abort; constant 0 without the macro.
- busy  out  1  high in any state other than IDLE.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  [WORDS]x16  registered operand A to the multiplier.
- mul_b  out  [WORDS]x16  registered operand B to the multiplier.
- mul_done  in  1  one-cycle completion pulse from the multiplier.
- mul_product  in  [WORDS]x16  multiplier result; valid only in the mul_done cycle.

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_err=0, rsp_data=0, mul_a=0, mul_b=0, mul_start=0, busy=0, state=IDLE, owner=0, prio_ptr=0.
- Reset applies from any state. An in-flight multiplication is abandoned and no response is issued. A mul_done arriving afterwards is ignored in IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching from prio_ptr upward, wrapping modulo NREQ.
  - Next edge: owner=winner, gnt[winner]=1, mul_a/mul_b loaded from the winner's operands, go to ISSUE.
- ISSUE:
  - mul_start=1 for exactly this cycle; next state is WAIT.
  - mul_done during ISSUE is ignored.
- WAIT:
  - On mul_done: rsp_data<=mul_product, go to RESP.
  - Otherwise remain in WAIT.
- RESP:
  - rsp_valid[owner]=1 for this cycle only, and gnt[owner] is still high.
  - Next edge: gnt=0, prio_ptr=(owner+1) mod NREQ, go to IDLE.
- Latency:
  - req seen in IDLE at cycle 0 → gnt and ISSUE at cycle 1 → WAIT at cycle 2.
  - mul_done at cycle k → rsp_valid at cycle k+1.
  - IDLE at k+2; earliest next grant at k+3.
- Fairness: after a grant, the owner has lowest priority in the next arbitration. Any requester therefore waits at most NREQ-1 other transactions.
- Simultaneous requests in IDLE resolve by prio_ptr.
- A requester re-asserting req in the cycle after its rsp_valid is eligible in the next IDLE, behind other pending requests.
- req dropped while granted: the transaction completes normally and rsp_valid still pulses; the requester may ignore it.
- Operands are sampled only at the latch edge. Changes to req_a/req_b afterwards do not affect the running multiplication.
- Exactly one gnt bit is high or none. rsp_valid is never high while more than one gnt bit is high.
- mul_done in IDLE or RESP is ignored and does not change rsp_data.

Optional Feature:
- E_MUL_ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without mul_done: rsp_data<=0, rsp_err=1 with rsp_valid[owner] in RESP, then normal return to IDLE.
  - If mul_done and the timeout coincide, mul_done wins and rsp_err=0.
- Not defined: no counter; WAIT waits indefinitely and rsp_err is tied to 0.

Test Plan:
- Single request: req[0]=1, A word0=3, B word0=5, multiplier model done after 10 cycles → one mul_start pulse; mul_a word0=3; rsp_valid[0] one cycle with rsp_data word0=15, others 0; gnt[0] low afterwards.
- Contention: req[0] and req[1] high together from reset with both held → grant order 0,1,0,1. Each rsp_valid goes only to the matching gnt owner.
- Operand stability: requester 1 changes req_a to 7 two cycles after its grant → product still computed from the original latched operand.
- Reset mid-operation: rst in WAIT, then a stray mul_done → all outputs return to reset values; no rsp_valid; rsp_data stays 0.
- Spurious done: mul_done pulsed in IDLE with mul_product=0xFFFF.. → no state change; rsp_data unchanged.
- Timeout (E_MUL_ARB_TIMEOUT_EN, TIMEOUT_CYC=20): multiplier never finishes → rsp_valid with rsp_err=1 and rsp_data=0 about 20 cycles after WAIT entry. A pending req[1] is then granted next.

Source files
------------

// File: rtl/e_mul_arbiter.sv
// Round-robin arbiter sharing one multi-limb multiplier between NREQ requesters.
// Optional watchdog abort in WAIT when E_MUL_ARB_TIMEOUT_EN is defined.
module e_mul_arbiter #(
   parameter int WORDS       = 32,
   parameter int NREQ        = 2,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NREQ-1:0]                     req,
   input  logic [NREQ-1:0][WORDS-1:0][15:0]    req_a,
   input  logic [NREQ-1:0][WORDS-1:0][15:0]    req_b,
   output logic [NREQ-1:0]                     gnt,
   output logic [NREQ-1:0]                     rsp_valid,
   output logic [WORDS-1:0][15:0]              rsp_data,
   output logic                                rsp_err,
   output logic                                busy,
   output logic                                mul_start,
   output logic [WORDS-1:0][15:0]              mul_a,
   output logic [WORDS-1:0][15:0]              mul_b,
   input  logic                                mul_done,
   input  logic [WORDS-1:0][15:0]              mul_product
);

   localparam int OW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [OW-1:0] owner;
   logic [OW-1:0] prio_ptr;
   logic [OW-1:0] win;
   logic          found;
   logic          any_req;
   logic          capture;
   logic          abort;

   assign any_req = |req;
   assign capture = (state == WAIT) && mul_done;

   // First set request bit at or above prio_ptr, wrapping.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[(int'(prio_ptr) + i) % NREQ]) begin
            found = 1'b1;
            win   = OW'((int'(prio_ptr) + i) % NREQ);
         end
      end
   end

`ifdef E_MUL_ARB_TIMEOUT_EN
   logic [31:0] tcnt;
   logic        err_q;

   // mul_done has precedence over the watchdog in the same cycle.
   assign abort   = (state == WAIT) && !mul_done
                    && (tcnt >= 32'(TIMEOUT_CYC - 1));
   assign rsp_err = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == ISSUE)
            tcnt <= '0;
         else if (state == WAIT)
            tcnt <= tcnt + 32'd1;
         if (abort)
            err_q <= 1'b1;
         else if (state == RESP)
            err_q <= 1'b0;
      end
   end
`else
   assign abort   = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (mul_done || abort) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt       = '0;
      rsp_valid = '0;
      if (state != IDLE)
         gnt[owner] = 1'b1;
      if (state == RESP)
         rsp_valid[owner] = 1'b1;
   end

   assign busy      = (state != IDLE);
   assign mul_start = (state == ISSUE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= '0;
         prio_ptr <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
         rsp_data <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_req) begin
            owner <= win;
            mul_a <= req_a[win];
            mul_b <= req_b[win];
         end
         if (capture)
            rsp_data <= mul_product;
         else if (abort)
            rsp_data <= '0;
         if (state == RESP)
            prio_ptr <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
   end

endmodule

// File: tb/tb_e_mul_arbiter.sv
// Directed bench for e_mul_arbiter with a latency-configurable multiplier model.
module tb_e_mul_arbiter;

   localparam int WORDS = 4;
   localparam int NREQ  = 2;

   logic                             clk;
   logic                             rst;
   logic [NREQ-1:0]                  req;
   logic [NREQ-1:0][WORDS-1:0][15:0] req_a;
   logic [NREQ-1:0][WORDS-1:0][15:0] req_b;
   logic [NREQ-1:0]                  gnt;
   logic [NREQ-1:0]                  rsp_valid;
   logic [WORDS-1:0][15:0]           rsp_data;
   logic                             rsp_err;
   logic                             busy;
   logic                             mul_start;
   logic [WORDS-1:0][15:0]           mul_a;
   logic [WORDS-1:0][15:0]           mul_b;
   logic                             mul_done;
   logic [WORDS-1:0][15:0]           mul_product;

   logic        model_done;
   logic [63:0] model_prod;
   logic        spur_done;
   logic [63:0] spur_prod;
   bit          model_en;
   int          mul_lat;
   int          starts;
   int          checks;
   int          errors;

   assign mul_done    = model_done | spur_done;
   assign mul_product = spur_done ? spur_prod : model_prod;

   e_mul_arbiter #(
      .WORDS(WORDS),
      .NREQ(NREQ),
      .TIMEOUT_CYC(20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .req_a(req_a),
      .req_b(req_b),
      .gnt(gnt),
      .rsp_valid(rsp_valid),
      .rsp_data(rsp_data),
      .rsp_err(rsp_err),
      .busy(busy),
      .mul_start(mul_start),
      .mul_a(mul_a),
      .mul_b(mul_b),
      .mul_done(mul_done),
      .mul_product(mul_product)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Multiplier model: done pulse mul_lat cycles after the start pulse.
   initial begin
      int          cnt;
      bit          mbusy;
      logic [63:0] la;
      logic [63:0] lb;
      model_done = 1'b0;
      model_prod = '0;
      cnt   = 0;
      mbusy = 1'b0;
      la    = '0;
      lb    = '0;
      forever begin
         @(negedge clk);
         model_done = 1'b0;
         if (mul_start) starts++;
         if (mul_start && model_en) begin
            la    = mul_a;
            lb    = mul_b;
            cnt   = mul_lat;
            mbusy = 1'b1;
         end else if (mbusy) begin
            cnt--;
            if (cnt <= 0) begin
               model_done = 1'b1;
               model_prod = la * lb;
               mbusy      = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_txn(input int who, input logic [63:0] exp,
                          input logic exp_err, input int chg_at,
                          input logic [63:0] chg_val, output int lat);
      bit granted;
      bit done;
      int g;
      granted = 1'b0;
      done    = 1'b0;
      g       = 0;
      lat     = -1;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (!granted && gnt != '0) begin
            granted = 1'b1;
            g       = 0;
            check("gnt_owner", gnt, 64'(1) << who);
         end else if (granted) begin
            g++;
         end
         if (granted && chg_at > 0 && g == chg_at)
            req_a[who] = chg_val;
         if (rsp_valid != '0) begin
            done = 1'b1;
            lat  = g;
            check("rsp_owner", rsp_valid, 64'(1) << who);
            check("rsp_gnt", gnt, 64'(1) << who);
            check("rsp_data", rsp_data, exp);
            check("rsp_err", rsp_err, exp_err);
         end
      end
      if (!done) check("rsp_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int lat;
      int nrsp;
      int stray;
      bit seen;
      checks    = 0;
      errors    = 0;
      starts    = 0;
      model_en  = 1'b1;
      mul_lat   = 10;
      spur_done = 1'b0;
      spur_prod = '0;
      rst       = 1'b1;
      req       = '0;
      req_a     = '0;
      req_b     = '0;
      repeat (3) @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);
      check("rst_mul_start", mul_start, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;

      // Single request
      @(negedge clk);
      starts   = 0;
      req_a[0] = 64'd3;
      req_b[0] = 64'd5;
      req      = 2'b01;
      @(negedge clk);
      check("single_gnt", gnt, 2'b01);
      check("single_start", mul_start, 1);
      check("single_mul_a", mul_a, 64'd3);
      check("single_mul_b", mul_b, 64'd5);
      check("single_busy", busy, 1);
      run_txn(0, 64'd15, 1'b0, 0, 64'd0, lat);
      req = '0;
      @(negedge clk);
      check("single_gnt_off", gnt, 0);
      check("single_idle", busy, 0);
      check("single_starts", starts, 1);

      // Contention from reset, with operand change mid-flight on requester 1
      rst      = 1'b1;
      mul_lat  = 4;
      req_a[0] = 64'd2;
      req_b[0] = 64'd3;
      req_a[1] = 64'd4;
      req_b[1] = 64'd5;
      req      = 2'b11;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_txn(0, 64'd6, 1'b0, 0, 64'd0, lat);
      run_txn(1, 64'd20, 1'b0, 2, 64'd7, lat);
      run_txn(0, 64'd6, 1'b0, 0, 64'd0, lat);
      run_txn(1, 64'd35, 1'b0, 0, 64'd0, lat);
      req = '0;
      repeat (3) @(negedge clk);

      // Reset during WAIT followed by a stray done
      mul_lat  = 8;
      req_a[0] = 64'd9;
      req_b[0] = 64'd9;
      req      = 2'b01;
      seen     = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = (gnt != '0);
      end
      check("midrst_granted", seen, 1);
      repeat (3) @(negedge clk);
      check("midrst_busy", busy, 1);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      check("midrst_gnt", gnt, 0);
      check("midrst_busy0", busy, 0);
      check("midrst_start", mul_start, 0);
      check("midrst_mul_a", mul_a, 0);
      check("midrst_data", rsp_data, 0);
      rst   = 1'b0;
      nrsp  = 0;
      stray = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (rsp_valid != '0) nrsp++;
         if (mul_done) stray++;
      end
      check("midrst_no_rsp", nrsp, 0);
      check("midrst_stray_seen", stray, 1);
      check("midrst_data_after", rsp_data, 0);
      check("midrst_idle", busy, 0);

      // Spurious done in IDLE
      mul_lat  = 3;
      req_a[0] = 64'd3;
      req_b[0] = 64'd5;
      req      = 2'b01;
      run_txn(0, 64'd15, 1'b0, 0, 64'd0, lat);
      req = '0;
      @(negedge clk);
      spur_prod = '1;
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      check("spur_busy", busy, 0);
      check("spur_gnt", gnt, 0);
      check("spur_data", rsp_data, 64'd15);
      @(negedge clk);
      check("spur_busy2", busy, 0);
      check("spur_start", mul_start, 0);
      check("spur_data2", rsp_data, 64'd15);

`ifdef E_MUL_ARB_TIMEOUT_EN
      // Watchdog abort, then the pending requester is served
      rst      = 1'b1;
      model_en = 1'b0;
      req_a[1] = 64'd2;
      req_b[1] = 64'd2;
      req      = 2'b11;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_txn(0, 64'd0, 1'b1, 0, 64'd0, lat);
      check("tmo_latency", (lat >= 19 && lat <= 23), 1);
      model_en = 1'b1;
      req[0]   = 1'b0;
      run_txn(1, 64'd4, 1'b0, 0, 64'd0, lat);
      req = '0;
      repeat (2) @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
